alu_ctrl: RTL and testbench

Command-side initiator for the 8-bit dual-group ALU. It accepts one operation per valid/ready handshake and drives the ALU enable, operand and opcode pins. It samples the registered result and interrupt, then clears the interrupt with an alu_irq_clr pulse. It returns the result on a valid/ready response channel and keeps a saturating interrupt counter for the system register file.

---
 rtl/alu_ctrl_pkg.sv | 67 ++++++
 rtl/alu_ctrl_model.sv | 46 ++++
 rtl/alu_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_alu_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_pkg
//  Description : Shared definitions for the alu_ctrl command initiator:
//                FSM state encoding, group-select values, per-group opcode
//                values and the eight ALU interrupt trigger values.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_CLEAR  = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Group A opcodes
  localparam logic [1:0] OPA_AND  = 2'b00;
  localparam logic [1:0] OPA_NAND = 2'b01;
  localparam logic [1:0] OPA_OR   = 2'b10;
  localparam logic [1:0] OPA_XOR  = 2'b11;

  // Group B opcodes
  localparam logic [1:0] OPB_XNOR = 2'b00;
  localparam logic [1:0] OPB_AND  = 2'b01;
  localparam logic [1:0] OPB_NOR  = 2'b10;
  localparam logic [1:0] OPB_OR   = 2'b11;

  // Result values on which the ALU raises its interrupt, per group/opcode
  localparam logic [7:0] IRQ_A_AND  = 8'hFF;
  localparam logic [7:0] IRQ_A_NAND = 8'h00;
  localparam logic [7:0] IRQ_A_OR   = 8'hF8;
  localparam logic [7:0] IRQ_A_XOR  = 8'h83;
  localparam logic [7:0] IRQ_B_XNOR = 8'hF1;
  localparam logic [7:0] IRQ_B_AND  = 8'hF4;
  localparam logic [7:0] IRQ_B_NOR  = 8'hF5;
  localparam logic [7:0] IRQ_B_OR   = 8'hFF;

  function automatic logic [7:0] irq_trigger(input logic sel, input logic [1:0] op);
    logic [7:0] v;
    v = 8'h00;
    if (sel == SEL_A) begin
      case (op)
        OPA_AND:  v = IRQ_A_AND;
        OPA_NAND: v = IRQ_A_NAND;
        OPA_OR:   v = IRQ_A_OR;
        default:  v = IRQ_A_XOR;
      endcase
    end else begin
      case (op)
        OPB_XNOR: v = IRQ_B_XNOR;
        OPB_AND:  v = IRQ_B_AND;
        OPB_NOR:  v = IRQ_B_NOR;
        default:  v = IRQ_B_OR;
      endcase
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_model.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_model
//  Description : Combinational golden model of the dual-group ALU. Produces
//                the expected result and interrupt for one command.
//  Ports       : sel_i    group select (0 = A, 1 = B)
//                op_i     opcode within the group
//                a_i/b_i  operands
//                result_o expected ALU result
//                irq_o    expected ALU interrupt
//  Revision    : 1.0  initial release
// ============================================================================
module alu_ctrl_model
  import alu_ctrl_pkg::*;
(
  input  logic       sel_i,
  input  logic [1:0] op_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] result_o,
  output logic       irq_o
);

  always_comb begin
    result_o = 8'h00;
    if (sel_i == SEL_A) begin
      case (op_i)
        OPA_AND:  result_o = a_i & b_i;
        OPA_NAND: result_o = ~(a_i & b_i);
        OPA_OR:   result_o = a_i | b_i;
        default:  result_o = a_i ^ b_i;
      endcase
    end else begin
      case (op_i)
        OPB_XNOR: result_o = ~(a_i ^ b_i);
        OPB_AND:  result_o = a_i & b_i;
        OPB_NOR:  result_o = ~(a_i | b_i);
        default:  result_o = a_i | b_i;
      endcase
    end
  end

  assign irq_o = (result_o == irq_trigger(sel_i, op_i));

endmodule
`default_nettype wire

// File: rtl/alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl
//  Description : Command-side initiator for the 8-bit dual-group ALU. Takes
//                one command per cmd handshake, drives registered ALU pins,
//                samples result/interrupt, pulses alu_irq_clr when needed and
//                returns the result on the rsp channel. Keeps a saturating
//                count of interrupting responses.
//  Config      : ALU_CTRL_CHECK_EN - build the golden model and drive
//                rsp_mismatch; otherwise rsp_mismatch is tied to 0.
//  Ports       : alu_clk/rst_n           clock, async active-low reset
//                cmd_*                   command channel (valid/ready)
//                rsp_*                   response channel (valid/ready)
//                irq_count/irq_count_clr interrupt counter and its clear
//                busy                    controller not idle
//                alu_*                   ALU-facing pins
//  Revision    : 1.0  initial release
// ============================================================================
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter bit AUTO_CLR  = 1'b1,
  parameter int IRQ_CNT_W = 8
) (
  input  logic                 alu_clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_sel,
  input  logic [1:0]           cmd_op,
  input  logic [7:0]           cmd_a,
  input  logic [7:0]           cmd_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [7:0]           rsp_data,
  output logic                 rsp_irq,
  output logic                 rsp_mismatch,
  output logic [IRQ_CNT_W-1:0] irq_count,
  input  logic                 irq_count_clr,
  output logic                 busy,
  output logic                 alu_enable,
  output logic                 alu_enable_a,
  output logic                 alu_enable_b,
  output logic [1:0]           alu_op_a,
  output logic [1:0]           alu_op_b,
  output logic [7:0]           alu_in_a,
  output logic [7:0]           alu_in_b,
  output logic                 alu_irq_clr,
  input  logic [7:0]           alu_out,
  input  logic                 alu_irq
);

  state_e               state_q, state_d;
  logic                 en_q, en_d;
  logic                 en_a_q, en_a_d;
  logic                 en_b_q, en_b_d;
  logic [1:0]           op_a_q, op_a_d;
  logic [1:0]           op_b_q, op_b_d;
  logic [7:0]           in_a_q, in_a_d;
  logic [7:0]           in_b_q, in_b_d;
  logic                 irq_clr_q, irq_clr_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [7:0]           rsp_data_q, rsp_data_d;
  logic                 rsp_irq_q, rsp_irq_d;
  logic                 mism_q, mism_d;
  logic [IRQ_CNT_W-1:0] cnt_q, cnt_d;
  logic                 w_mismatch;

`ifdef ALU_CTRL_CHECK_EN
  logic [7:0] w_exp_result;
  logic       w_exp_irq;

  // The enables are still held while sampling, so enable_b names the group
  // of the command in flight without a separate select register.
  alu_ctrl_model u_model (
    .sel_i    (en_b_q),
    .op_i     (en_b_q ? op_b_q : op_a_q),
    .a_i      (in_a_q),
    .b_i      (in_b_q),
    .result_o (w_exp_result),
    .irq_o    (w_exp_irq)
  );

  assign w_mismatch = (alu_out != w_exp_result) || (alu_irq != w_exp_irq);
`else
  assign w_mismatch = 1'b0;
`endif

  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      en_q        <= 1'b0;
      en_a_q      <= 1'b0;
      en_b_q      <= 1'b0;
      op_a_q      <= 2'b00;
      op_b_q      <= 2'b00;
      in_a_q      <= 8'h00;
      in_b_q      <= 8'h00;
      irq_clr_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_irq_q   <= 1'b0;
      mism_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      en_a_q      <= en_a_d;
      en_b_q      <= en_b_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      in_a_q      <= in_a_d;
      in_b_q      <= in_b_d;
      irq_clr_q   <= irq_clr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_irq_q   <= rsp_irq_d;
      mism_q      <= mism_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    en_a_d      = en_a_q;
    en_b_d      = en_b_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    in_a_d      = in_a_q;
    in_b_d      = in_b_q;
    irq_clr_d   = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_irq_d   = rsp_irq_q;
    mism_d      = mism_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_ISSUE;
          en_d    = 1'b1;
          en_a_d  = (cmd_sel == SEL_A);
          en_b_d  = (cmd_sel == SEL_B);
          op_a_d  = (cmd_sel == SEL_A) ? cmd_op : 2'b00;
          op_b_d  = (cmd_sel == SEL_B) ? cmd_op : 2'b00;
          in_a_d  = cmd_a;
          in_b_d  = cmd_b;
        end
      end
      ST_ISSUE: begin
        state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        rsp_data_d = alu_out;
        rsp_irq_d  = alu_irq;
        mism_d     = w_mismatch;
        if (alu_irq && AUTO_CLR) begin
          state_d   = ST_CLEAR;
          irq_clr_d = 1'b1;
        end else begin
          state_d     = ST_RESP;
          en_d        = 1'b0;
          en_a_d      = 1'b0;
          en_b_d      = 1'b0;
          rsp_valid_d = 1'b1;
        end
      end
      ST_CLEAR: begin
        state_d     = ST_RESP;
        en_d        = 1'b0;
        en_a_d      = 1'b0;
        en_b_d      = 1'b0;
        rsp_valid_d = 1'b1;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Clear wins over a same-cycle increment; increment saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (irq_count_clr) begin
      cnt_d = '0;
    end else if (rsp_valid_q && rsp_ready && rsp_irq_q && (cnt_q != {IRQ_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Gated by rst_n so that every output reads 0 while reset is asserted.
  assign cmd_ready    = rst_n && (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_irq      = rsp_irq_q;
  assign rsp_mismatch = mism_q;
  assign irq_count    = cnt_q;
  assign alu_enable   = en_q;
  assign alu_enable_a = en_a_q;
  assign alu_enable_b = en_b_q;
  assign alu_op_a     = op_a_q;
  assign alu_op_b     = op_b_q;
  assign alu_in_a     = in_a_q;
  assign alu_in_b     = in_b_q;
  assign alu_irq_clr  = irq_clr_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_alu_ctrl
//  Description : Directed self-checking bench for alu_ctrl, with a small
//                behavioural model of the dual-group ALU on the pin side.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_ctrl;

  logic       alu_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_sel = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_a = 8'h00;
  logic [7:0] cmd_b = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_irq;
  logic       rsp_mismatch;
  logic [7:0] irq_count;
  logic       irq_count_clr = 1'b0;
  logic       busy;
  logic       alu_enable, alu_enable_a, alu_enable_b;
  logic [1:0] alu_op_a, alu_op_b;
  logic [7:0] alu_in_a, alu_in_b;
  logic       alu_irq_clr;
  logic [7:0] alu_out;
  logic       alu_irq;

  int tests = 0;
  int fails = 0;

`ifdef ALU_CTRL_CHECK_EN
  localparam bit EXP_MISM_FORCED = 1'b1;
`else
  localparam bit EXP_MISM_FORCED = 1'b0;
`endif

  always #5 alu_clk = ~alu_clk;

  alu_ctrl #(.AUTO_CLR(1'b1), .IRQ_CNT_W(8)) dut (
    .alu_clk(alu_clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_irq(rsp_irq), .rsp_mismatch(rsp_mismatch),
    .irq_count(irq_count), .irq_count_clr(irq_count_clr), .busy(busy),
    .alu_enable(alu_enable), .alu_enable_a(alu_enable_a), .alu_enable_b(alu_enable_b),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_irq_clr(alu_irq_clr), .alu_out(alu_out), .alu_irq(alu_irq)
  );

  // ---------------- behavioural ALU ----------------
  logic [7:0] alu_reg;
  logic       force_zero = 1'b0;

  function automatic logic [7:0] alu_f(input logic g, input logic [1:0] op,
                                       input logic [7:0] a, input logic [7:0] b);
    if (!g) begin
      case (op)
        2'd0: return a & b;
        2'd1: return ~(a & b);
        2'd2: return a | b;
        default: return a ^ b;
      endcase
    end else begin
      case (op)
        2'd0: return ~(a ^ b);
        2'd1: return a & b;
        2'd2: return ~(a | b);
        default: return a | b;
      endcase
    end
  endfunction

  function automatic logic [7:0] trig_f(input logic g, input logic [1:0] op);
    logic [7:0] ta [4];
    logic [7:0] tb [4];
    ta = '{8'hFF, 8'h00, 8'hF8, 8'h83};
    tb = '{8'hF1, 8'hF4, 8'hF5, 8'hFF};
    return g ? tb[op] : ta[op];
  endfunction

  always @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n)           alu_reg <= 8'h00;
    else if (alu_irq_clr) alu_reg <= 8'h00;
    else if (alu_enable)  alu_reg <= alu_f(alu_enable_b, alu_enable_b ? alu_op_b : alu_op_a,
                                           alu_in_a, alu_in_b);
  end

  assign alu_out = force_zero ? 8'h00 : alu_reg;
  assign alu_irq = alu_enable &&
                   (alu_reg == trig_f(alu_enable_b, alu_enable_b ? alu_op_b : alu_op_a));

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge alu_clk);
    #1;
  endtask

  // Presents one command and returns right after its acceptance edge.
  task automatic issue(input logic s, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: cmd_ready got %b, expected 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_sel = s; cmd_op = op; cmd_a = a; cmd_b = b;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Full transaction: issue, wait for rsp_valid, handshake (optionally with clear).
  task automatic run_txn(input logic s, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic clr,
                         output logic [7:0] d, output logic irq, output logic mism);
    int n;
    issue(s, op, a, b);
    n = 0;
    while (!rsp_valid && n < 10) begin
      tick();
      n++;
    end
    if (!rsp_valid) begin
      tests++;
      fails++;
      $display("FAIL rsp_timeout: rsp_valid got %b, expected 1", rsp_valid);
    end
    d = rsp_data; irq = rsp_irq; mism = rsp_mismatch;
    rsp_ready = 1'b1;
    irq_count_clr = clr;
    tick();
    rsp_ready = 1'b0;
    irq_count_clr = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [39:0] outs;
    #3;
    outs = {cmd_ready, rsp_valid, rsp_data, rsp_irq, rsp_mismatch, irq_count, busy,
            alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b, alu_irq_clr};
    tests++;
    if (outs !== 40'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, expected %h", outs, 40'h0);
    end
    tests++;
    if ({alu_in_a, alu_in_b} !== 16'h0) begin
      fails++;
      $display("FAIL reset_operands: got %h, expected 0000", {alu_in_a, alu_in_b});
    end
    tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if ({cmd_ready, busy} !== 2'b10) begin
      fails++;
      $display("FAIL reset_idle: {ready,busy} got %b, expected 10", {cmd_ready, busy});
    end
  endtask

  task automatic test_reset_mid_sample();
    logic seen;
    issue(1'b0, 2'b11, 8'h80, 8'h03);
    tick();                     // now in SAMPLE
    tests++;
    if (busy !== 1'b1 || alu_enable !== 1'b1) begin
      fails++;
      $display("FAIL mid_busy: {busy,en} got %b%b, expected 11", busy, alu_enable);
    end
    rst_n = 1'b0;
    tick();
    tests++;
    if ({cmd_ready, rsp_valid, busy, alu_enable, alu_enable_a, alu_enable_b,
         alu_op_a, alu_irq_clr, alu_in_a, alu_in_b, irq_count} !== 41'h0) begin
      fails++;
      $display("FAIL mid_reset_outputs: busy %b en %b ina %h, expected all 0",
               busy, alu_enable, alu_in_a);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid || busy) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_no_rsp: activity got %b, expected 0", seen);
    end
  endtask

  task automatic test_xor_noirq();
    logic [2:0] vseq;
    logic       clr_seen;
    issue(1'b0, 2'b11, 8'h0F, 8'hF0);
    tests++;
    if ({alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b} !== 7'b110_1100) begin
      fails++;
      $display("FAIL xor_pins: got %b, expected 1101100",
               {alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b});
    end
    vseq[0] = rsp_valid; clr_seen = alu_irq_clr;
    tick(); vseq[1] = rsp_valid; clr_seen |= alu_irq_clr;
    tick(); vseq[2] = rsp_valid; clr_seen |= alu_irq_clr;
    tests++;
    if (vseq !== 3'b100) begin
      fails++;
      $display("FAIL xor_latency: rsp_valid cycles 3..1 got %b, expected 100", vseq);
    end
    tests++;
    if ({rsp_data, rsp_irq, rsp_mismatch, clr_seen, alu_enable} !== {8'hFF, 4'b0000}) begin
      fails++;
      $display("FAIL xor_rsp: data %h irq %b mism %b clr %b en %b, expected FF 0 0 0 0",
               rsp_data, rsp_irq, rsp_mismatch, clr_seen, alu_enable);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tests++;
    if ({cmd_ready, rsp_valid, irq_count} !== {2'b10, 8'd0}) begin
      fails++;
      $display("FAIL xor_done: ready %b valid %b cnt %0d, expected 1 0 0",
               cmd_ready, rsp_valid, irq_count);
    end
  endtask

  task automatic test_irq_clear();
    logic [3:0] clr_seq, v_seq;
    issue(1'b0, 2'b11, 8'h80, 8'h03);
    clr_seq[0] = alu_irq_clr; v_seq[0] = rsp_valid;
    tick(); clr_seq[1] = alu_irq_clr; v_seq[1] = rsp_valid;
    tick(); clr_seq[2] = alu_irq_clr; v_seq[2] = rsp_valid;
    tick(); clr_seq[3] = alu_irq_clr; v_seq[3] = rsp_valid;
    tests++;
    if (clr_seq !== 4'b0100) begin
      fails++;
      $display("FAIL irq_clr_pulse: cycles 4..1 got %b, expected 0100", clr_seq);
    end
    tests++;
    if (v_seq !== 4'b1000) begin
      fails++;
      $display("FAIL irq_latency: rsp_valid cycles 4..1 got %b, expected 1000", v_seq);
    end
    tests++;
    if ({rsp_data, rsp_irq, alu_out, alu_enable} !== {8'h83, 1'b1, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL irq_rsp: data %h irq %b alu_out %h en %b, expected 83 1 00 0",
               rsp_data, rsp_irq, alu_out, alu_enable);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tests++;
    if (irq_count !== 8'd1) begin
      fails++;
      $display("FAIL irq_count_one: got %0d, expected 1", irq_count);
    end
  endtask

  task automatic test_backpressure();
    logic bad;
    issue(1'b1, 2'b11, 8'hF0, 8'h0F);
    tests++;
    if ({alu_enable_a, alu_enable_b, alu_op_a, alu_op_b} !== 6'b01_00_11) begin
      fails++;
      $display("FAIL b_pins: got %b, expected 010011",
               {alu_enable_a, alu_enable_b, alu_op_a, alu_op_b});
    end
    tick(); tick(); tick();     // ISSUE, SAMPLE, CLEAR -> now RESP
    cmd_valid = 1'b1; cmd_sel = 1'b0; cmd_op = 2'b00; cmd_a = 8'h11; cmd_b = 8'h22;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 8'hFF || rsp_irq !== 1'b1 ||
          cmd_ready !== 1'b0 || alu_enable !== 1'b0) bad = 1'b1;
      tick();
    end
    tests++;
    if (bad !== 1'b0) begin
      fails++;
      $display("FAIL bp_stable: unstable got %b, expected 0 (data %h irq %b)",
               bad, rsp_data, rsp_irq);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tests++;
    if ({cmd_ready, busy, irq_count} !== {2'b10, 8'd2}) begin
      fails++;
      $display("FAIL bp_done: ready %b busy %b cnt %0d, expected 1 0 2",
               cmd_ready, busy, irq_count);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] d;
    logic irq, mism;
    for (int i = 0; i < 253; i++) run_txn(1'b0, 2'b11, 8'h80, 8'h03, 1'b0, d, irq, mism);
    tests++;
    if (irq_count !== 8'hFF) begin
      fails++;
      $display("FAIL sat_reach: got %h, expected FF", irq_count);
    end
    run_txn(1'b0, 2'b11, 8'h80, 8'h03, 1'b0, d, irq, mism);
    tests++;
    if (irq_count !== 8'hFF) begin
      fails++;
      $display("FAIL sat_hold: got %h, expected FF", irq_count);
    end
    run_txn(1'b0, 2'b11, 8'h80, 8'h03, 1'b1, d, irq, mism);
    tests++;
    if (irq_count !== 8'h00) begin
      fails++;
      $display("FAIL clr_priority: got %h, expected 00", irq_count);
    end
    run_txn(1'b1, 2'b00, 8'h0E, 8'h00, 1'b0, d, irq, mism);  // XNOR -> F1, irq
    tests++;
    if ({d, irq, irq_count} !== {8'hF1, 1'b1, 8'h01}) begin
      fails++;
      $display("FAIL xnor_irq: data %h irq %b cnt %h, expected F1 1 01", d, irq, irq_count);
    end
  endtask

  task automatic test_mismatch();
    logic [7:0] d;
    logic irq, mism;
    force_zero = 1'b1;
    run_txn(1'b1, 2'b01, 8'hF4, 8'hF4, 1'b0, d, irq, mism);
    force_zero = 1'b0;
    tests++;
    if ({d, irq, mism} !== {8'h00, 1'b1, EXP_MISM_FORCED}) begin
      fails++;
      $display("FAIL mism_forced: data %h irq %b mism %b, expected 00 1 %b",
               d, irq, mism, EXP_MISM_FORCED);
    end
    run_txn(1'b1, 2'b01, 8'hF4, 8'hF4, 1'b0, d, irq, mism);
    tests++;
    if ({d, irq, mism} !== {8'hF4, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL mism_clean: data %h irq %b mism %b, expected F4 1 0", d, irq, mism);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_sample();
    test_xor_noirq();
    test_irq_clear();
    test_backpressure();
    test_saturation();
    test_mismatch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
